// File: rtl/moonbase_bus_bridge.sv
// Bus bridge for the moonbase 8-bit CPU: address latch, banked nibble memory,
// GPIO and a prescaled reloadable timer, plus a boot loader port usable while in reset.
module moonbase_bus_bridge #(
    parameter int RAM_ADDR_BITS = 6,
    parameter int MAX_COUNT     = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               cpu_out,
    output logic [3:0]               ram_data,
    output logic [1:0]               dev_data,
    input  logic                     load_en,
    input  logic [RAM_ADDR_BITS+1:0] load_addr,
    input  logic [3:0]               load_data,
    input  logic [7:0]               gpio_in,
    output logic [7:0]               gpio_out,
    output logic [7:0]               timer_out
);

    localparam int NIB_BITS = RAM_ADDR_BITS + 2;
    localparam int DEPTH    = 1 << NIB_BITS;
    localparam int PW       = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    // Assertion is immediate; release is delayed by two clk edges.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic       strobe, nib, wr_ram, wr_dev;
    logic [5:0] pay;
    logic [3:0] din;

    assign strobe = cpu_out[7];
    assign nib    = cpu_out[6];
    assign pay    = cpu_out[5:0];
    assign din    = cpu_out[3:0];
    assign wr_ram = !strobe && !pay[5];
    assign wr_dev = !strobe && !pay[4];

    logic [11:0]   latch_q, latch_d;
    logic          bank_q, bank_d;
    logic [7:0]    gpio_q, gpio_d;
    logic [7:0]    reload_q, reload_d;
    logic [7:0]    timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        latch_d  = latch_q;
        bank_d   = bank_q;
        gpio_d   = gpio_q;
        reload_d = reload_q;
        timer_d  = timer_q;
        presc_d  = presc_q + 1'b1;

        if (presc_q == PW'(MAX_COUNT - 1)) begin
            presc_d = '0;
            timer_d = (timer_q == 8'hFF) ? reload_q : timer_q + 8'd1;
        end

        if (strobe) begin
            if (nib) begin
                latch_d[11:6] = pay;
                bank_d        = cpu_out[6];
            end else begin
                latch_d[5:0]  = pay;
            end
        end

        // A reload write overrides whatever the prescaler wrap decided above.
        if (wr_dev) begin
            case (latch_q[1:0])
                2'd0: begin
                    if (nib) gpio_d[3:0] = din;
                    else     gpio_d[7:4] = din;
                end
                2'd1: begin
                    if (nib) begin
                        reload_d[3:0] = din;
                        timer_d       = {reload_q[7:4], din};
                        presc_d       = '0;
                    end else begin
                        reload_d[7:4] = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            latch_q  <= '0;
            bank_q   <= 1'b0;
            gpio_q   <= '0;
            reload_q <= '0;
            timer_q  <= '0;
            presc_q  <= '0;
        end else begin
            latch_q  <= latch_d;
            bank_q   <= bank_d;
            gpio_q   <= gpio_d;
            reload_q <= reload_d;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
        end
    end

    // Latched address bits above RAM_ADDR_BITS are deliberately ignored (aliasing).
    logic unused_latch;
    assign unused_latch = ^latch_q;

    logic [3:0]          mem_q [DEPTH];
    logic [NIB_BITS-1:0] nib_idx;

    assign nib_idx = {bank_q, latch_q[RAM_ADDR_BITS-1:0], nib};

    always_ff @(posedge clk) begin
        if (!rst_n_int && load_en) mem_q[load_addr] <= load_data;
        else if (rst_n_int && wr_ram) mem_q[nib_idx] <= din;
    end

    assign ram_data = mem_q[nib_idx];

    logic [7:0] dev_src;
    logic [1:0] dev_slice;

    assign dev_src   = latch_q[1] ? timer_q : gpio_in;
    assign dev_slice = {latch_q[0], nib};
    assign dev_data  = dev_src[{dev_slice, 1'b0} +: 2];

    assign gpio_out  = gpio_q;
    assign timer_out = timer_q;

endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// Randomized bench for moonbase_bus_bridge against a byte-level behavioural model.
module tb_moonbase_bus_bridge;

    localparam int RAB = 6;
    localparam int MC  = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [7:0]     cpu_out;
    logic [3:0]     ram_data;
    logic [1:0]     dev_data;
    logic           load_en;
    logic [RAB+1:0] load_addr;
    logic [3:0]     load_data;
    logic [7:0]     gpio_in;
    logic [7:0]     gpio_out;
    logic [7:0]     timer_out;

    always #5 clk = ~clk;

    moonbase_bus_bridge #(.RAM_ADDR_BITS(RAB), .MAX_COUNT(MC)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_out(cpu_out), .ram_data(ram_data),
        .dev_data(dev_data), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .timer_out(timer_out)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: memory kept as whole bytes; nibble 0 is the high half of a byte.
    int m_mem [2][64];
    int m_latch, m_bank, m_gpio, m_reload, m_timer, m_presc;
    logic [3:0] last_ram;
    logic [1:0] last_dev;

    function automatic void model_clear();
        m_latch = 0; m_bank = 0; m_gpio = 0; m_reload = 0; m_timer = 0; m_presc = 0;
    endfunction

    function automatic int set_nib(input int v, input int which, input int d);
        return which ? (v / 16) * 16 + d : d * 16 + (v % 16);
    endfunction

    function automatic void model_edge(input logic [7:0] cpu);
        int nb, pay, d;
        nb  = int'(cpu[6]);
        pay = int'(cpu[5:0]);
        d   = int'(cpu[3:0]);
        m_presc++;
        if (m_presc == MC) begin
            m_presc = 0;
            m_timer = (m_timer == 255) ? m_reload : m_timer + 1;
        end
        if (cpu[7]) begin
            if (nb == 1) begin
                m_latch = m_latch % 64 + pay * 64;
                m_bank  = 1;
            end else begin
                m_latch = (m_latch / 64) * 64 + pay;
            end
        end else begin
            if (!cpu[5]) m_mem[m_bank][m_latch % 64] = set_nib(m_mem[m_bank][m_latch % 64], nb, d);
            if (!cpu[4]) begin
                if (m_latch % 4 == 0) m_gpio = set_nib(m_gpio, nb, d);
                if (m_latch % 4 == 1) begin
                    m_reload = set_nib(m_reload, nb, d);
                    if (nb == 1) begin
                        m_timer = m_reload;
                        m_presc = 0;
                    end
                end
            end
        end
    endfunction

    // One bus cycle: starts 1 time unit after a rising edge and ends there too.
    task automatic step(input logic [7:0] cpu, input logic [7:0] gin, input logic ld);
        int nb, v, s, src;
        cpu_out   = cpu;
        gpio_in   = gin;
        load_en   = ld;
        load_addr = (RAB + 2)'($urandom);
        load_data = 4'($urandom);
        @(negedge clk);
        nb  = int'(cpu[6]);
        v   = m_mem[m_bank][m_latch % 64];
        s   = (m_latch % 2) * 2 + nb;
        src = ((m_latch / 2) % 2 == 1) ? m_timer : int'(gin);
        last_ram = ram_data;
        last_dev = dev_data;
        check_val("ram_data", ram_data, 8'(nb ? v % 16 : v / 16));
        check_val("dev_data", dev_data, 8'((src >> (2 * s)) % 4));
        @(posedge clk);
        model_edge(cpu);
        #1;
        check_val("gpio_out", gpio_out, 8'(m_gpio));
        check_val("timer_out", timer_out, 8'(m_timer));
    endtask

    task automatic do_reset(input bit preload);
        int v;
        #2;
        reset_n = 1'b0;
        cpu_out = 8'h30;
        load_en = 1'b0;
        #1;
        check_val("rst_gpio", gpio_out, 8'h00);
        check_val("rst_timer", timer_out, 8'h00);
        model_clear();
        if (preload) begin
            for (int i = 0; i < 128; i++) begin
                if (i == 64)      v = 8'hF0;
                else if (i == 65) v = 8'h5A;
                else              v = int'($urandom_range(0, 255));
                m_mem[i / 64][i % 64] = v;
                for (int n = 0; n < 2; n++) begin
                    @(negedge clk);
                    load_en   = 1'b1;
                    load_addr = (RAB + 2)'(i * 2 + n);
                    load_data = 4'(n == 1 ? v % 16 : v / 16);
                end
            end
            @(negedge clk);
            load_en = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d_new, lo_old;
        logic [7:0] c;
        reset_n = 1'b1; cpu_out = 8'h30; load_en = 1'b0; load_addr = '0;
        load_data = '0; gpio_in = 8'h00;
        model_clear();
        @(posedge clk); #1;
        do_reset(1'b1);

        // Loaded code bank bytes, then a 0x041 address aliasing onto byte 1.
        step(8'h80, 8'h00, 0); step(8'hC0, 8'h00, 0);
        step(8'h30, 8'h00, 0); check_val("tp_b0_hi", last_ram, 8'hF);
        step(8'h70, 8'h00, 0); check_val("tp_b0_lo", last_ram, 8'h0);
        step(8'h81, 8'h00, 0); step(8'hC1, 8'h00, 0);
        step(8'h30, 8'h00, 0); check_val("tp_alias_hi", last_ram, 8'h5);
        step(8'h70, 8'h00, 0); check_val("tp_alias_lo", last_ram, 8'hA);

        // Data bank write at byte 3, then the same cycles with writes disabled.
        do_reset(1'b0);
        step(8'h83, 8'h00, 0); step(8'h1C, 8'h00, 0); step(8'h53, 8'h00, 0);
        step(8'h30, 8'h00, 0); check_val("tp_wr_hi", last_ram, 8'hC);
        step(8'h70, 8'h00, 0); check_val("tp_wr_lo", last_ram, 8'h3);
        step(8'h35, 8'h00, 0); step(8'h75, 8'h00, 0);
        step(8'h30, 8'h00, 0); check_val("tp_nowr_hi", last_ram, 8'hC);
        step(8'h70, 8'h00, 0); check_val("tp_nowr_lo", last_ram, 8'h3);

        // GPIO write and sliced reads.
        step(8'h80, 8'hB4, 0); step(8'h29, 8'hB4, 0); step(8'h66, 8'hB4, 0);
        check_val("tp_gpio", gpio_out, 8'h96);
        step(8'h30, 8'hB4, 0); check_val("tp_gin_s0", last_dev, 8'h0);
        step(8'h70, 8'hB4, 0); check_val("tp_gin_s1", last_dev, 8'h1);
        step(8'h82, 8'hB4, 0); step(8'h30, 8'hB4, 0); step(8'h70, 8'hB4, 0);

        // Timer reload, wrap past 0xFF to reload, reload colliding with a wrap.
        step(8'h81, 8'h00, 0); step(8'h2F, 8'h00, 0); step(8'h6E, 8'h00, 0);
        check_val("tp_reload", timer_out, 8'hFE);
        for (int i = 0; i < 4; i++) step(8'h30, 8'h00, 0);
        check_val("tp_tick", timer_out, 8'hFF);
        for (int i = 0; i < 4; i++) step(8'h30, 8'h00, 0);
        check_val("tp_wrap", timer_out, 8'hFE);
        step(8'h30, 8'h00, 0); step(8'h30, 8'h00, 0);
        step(8'h2A, 8'h00, 0); step(8'h6B, 8'h00, 0);
        check_val("tp_reload_wins", timer_out, 8'hAB);

        // Reset between the two nibbles of a byte write aborts the second one.
        do_reset(1'b0);
        d_new  = 4'(~(m_mem[0][0] / 16));
        lo_old = 4'(m_mem[0][0] % 16);
        step({4'h1, d_new}, 8'h00, 0);
        do_reset(1'b0);
        step(8'h30, 8'h00, 0); check_val("abort_hi", last_ram, 8'(d_new));
        step(8'h70, 8'h00, 0); check_val("abort_lo", last_ram, 8'(lo_old));

        // Random traffic, including loader strobes outside reset that must be ignored.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1'b0);
            c = 8'($urandom);
            if ($urandom_range(0, 3) != 0) c[7] = 1'b0;
            step(c, 8'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
